beam_bounce: RTL and testbench

Multi-square bouncing animation generator for 640x480 VGA beam-racing designs. It generalises the single-square wrap-around demo to NQ independently moving squares that reflect off the active-area edges. Each square has a colour, and lower indices win where squares overlap. It sits between simple_display_timings_480p, which supplies sx/sy/hsync/vsync/de, and the Pmod VGA pins, adding one registered output stage.

---
 rtl/beam_bounce.sv | 122 ++++++++++++
 tb/tb_beam_bounce.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/beam_bounce.sv
// beam_bounce: NQ coloured squares bouncing off the 640x480 active edges,
// stepped once per frame, with a single registered VGA output stage.
module beam_bounce #(
    parameter int CORDW   = 10,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int NQ      = 4,
    parameter int Q_SIZE  = 32,
    parameter int Q_SPEED = 4,
    parameter int CHANW   = 3
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    input  logic             pause,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic [CHANW-1:0] vga_r,
    output logic [CHANW-1:0] vga_g,
    output logic [CHANW-1:0] vga_b
);
    localparam int CW1 = CORDW + 1;
    localparam logic [CORDW:0] L_SIZE  = CW1'(Q_SIZE);
    localparam logic [CORDW:0] L_SPEED = CW1'(Q_SPEED);
    localparam logic [CORDW:0] L_HRES  = CW1'(H_RES);
    localparam logic [CORDW:0] L_VRES  = CW1'(V_RES);

    if (NQ < 1 || NQ > 7 || Q_SPEED < 1 || Q_SPEED >= Q_SIZE ||
        (2*NQ-1)*Q_SIZE > H_RES-Q_SIZE || NQ*Q_SIZE > V_RES-Q_SIZE)
    begin : g_bad_cfg
        $error("beam_bounce: square layout does not fit the screen");
    end

    logic [CORDW-1:0] r_qx [NQ];
    logic [CORDW-1:0] r_qy [NQ];
    logic [NQ-1:0]    r_dx;
    logic [NQ-1:0]    r_dy;
    logic             w_animate;
    logic [CHANW-1:0] w_r;
    logic [CHANW-1:0] w_g;
    logic [CHANW-1:0] w_b;

    // Returns {new direction, new position} for one axis.
    function automatic logic [CORDW:0] f_step(
        input logic [CORDW-1:0] q,
        input logic             d,
        input logic [CORDW:0]   res
    );
        logic [CORDW:0] w_q;
        logic [CORDW:0] w_out;
        w_q = {1'b0, q};
        if (d) begin
            if (w_q + L_SIZE + L_SPEED > res)
                w_out = {1'b0, CORDW'(res - L_SIZE)};
            else
                w_out = {1'b1, CORDW'(w_q + L_SPEED)};
        end else begin
            if (w_q < L_SPEED)
                w_out = {1'b1, {CORDW{1'b0}}};
            else
                w_out = {1'b0, CORDW'(w_q - L_SPEED)};
        end
        return w_out;
    endfunction

    assign w_animate = (sy == CORDW'(V_RES)) && (sx == '0);

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            for (int i = 0; i < NQ; i++) begin
                r_qx[i] <= CORDW'(2 * i * Q_SIZE);
                r_qy[i] <= CORDW'(i * Q_SIZE);
                r_dx[i] <= ((i % 2) == 0);
                r_dy[i] <= 1'b1;
            end
        end else if (w_animate && !pause) begin
            for (int i = 0; i < NQ; i++) begin
                {r_dx[i], r_qx[i]} <= f_step(r_qx[i], r_dx[i], L_HRES);
                {r_dy[i], r_qy[i]} <= f_step(r_qy[i], r_dy[i], L_VRES);
            end
        end
    end

    // Walk from the highest index down so the lowest hit index wins.
    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        w_b[CHANW-1] = 1'b1;
        for (int i = NQ - 1; i >= 0; i--) begin
            if ({1'b0, sx} >= {1'b0, r_qx[i]} &&
                {1'b0, sx} <  {1'b0, r_qx[i]} + L_SIZE &&
                {1'b0, sy} >= {1'b0, r_qy[i]} &&
                {1'b0, sy} <  {1'b0, r_qy[i]} + L_SIZE) begin
                w_r = {CHANW{((i + 1) % 2) == 1}};
                w_g = {CHANW{(((i + 1) / 2) % 2) == 1}};
                w_b = {CHANW{(((i + 1) / 4) % 2) == 1}};
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else begin
            vga_hsync <= hsync;
            vga_vsync <= vsync;
            vga_r     <= de ? w_r : '0;
            vga_g     <= de ? w_g : '0;
            vga_b     <= de ? w_b : '0;
        end
    end

endmodule

// File: tb/tb_beam_bounce.sv
// Directed bench for beam_bounce: reset, stepping, wall/corner bounces,
// priority, blanking, sync delay, pause and reset races.
module tb_beam_bounce;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sx = '0;
    logic [9:0] sy = '0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic       de = 1'b0;
    logic       pause = 1'b0;

    logic       hs4, vs4, hs1, vs1, hsp, vsp, hsc, vsc;
    logic [2:0] r4, g4, b4, r1, g1, b1, rp, gp, bp, rc, gc, bc;
    logic [8:0] c4, c1, cp, cc;

    int nvec = 0;
    int nerr = 0;

    localparam logic [8:0] RED = 9'o700;
    localparam logic [8:0] GRN = 9'o070;
    localparam logic [8:0] YEL = 9'o770;
    localparam logic [8:0] BLU = 9'o007;
    localparam logic [8:0] BG  = 9'o004;

    assign c4 = {r4, g4, b4};
    assign c1 = {r1, g1, b1};
    assign cp = {rp, gp, bp};
    assign cc = {rc, gc, bc};

    always #5 clk = ~clk;

    beam_bounce u_dut4 (
        .clk_pix(clk), .rst(rst), .sx(sx), .sy(sy),
        .hsync(hsync), .vsync(vsync), .de(de), .pause(pause),
        .vga_hsync(hs4), .vga_vsync(vs4),
        .vga_r(r4), .vga_g(g4), .vga_b(b4)
    );

    beam_bounce #(.NQ(1)) u_dut1 (
        .clk_pix(clk), .rst(rst), .sx(sx), .sy(sy),
        .hsync(hsync), .vsync(vsync), .de(de), .pause(pause),
        .vga_hsync(hs1), .vga_vsync(vs1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1)
    );

    beam_bounce #(.NQ(2), .V_RES(96)) u_dp (
        .clk_pix(clk), .rst(rst), .sx(sx), .sy(sy),
        .hsync(hsync), .vsync(vsync), .de(de), .pause(pause),
        .vga_hsync(hsp), .vga_vsync(vsp),
        .vga_r(rp), .vga_g(gp), .vga_b(bp)
    );

    beam_bounce #(.NQ(1), .H_RES(70), .V_RES(70)) u_uc (
        .clk_pix(clk), .rst(rst), .sx(sx), .sy(sy),
        .hsync(hsync), .vsync(vsync), .de(de), .pause(pause),
        .vga_hsync(hsc), .vga_vsync(vsc),
        .vga_r(rc), .vga_g(gc), .vga_b(bc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] got,
                       input logic [8:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%o expected=%o", tag, got, exp);
        end
    endtask

    task automatic px(input int x, input int y);
        sx = 10'(x);
        sy = 10'(y);
        de = 1'b1;
        hsync = 1'b0;
        vsync = 1'b0;
        tick();
    endtask

    task automatic anim(input int row, input int n);
        repeat (n) begin
            sx = '0;
            sy = 10'(row);
            de = 1'b0;
            tick();
            sx = 10'd1;
            sy = 10'd0;
            tick();
        end
    endtask

    initial begin
        // reset holds outputs at zero even with active inputs
        rst = 1'b1; sx = 10'd5; sy = 10'd5;
        de = 1'b1; hsync = 1'b1; vsync = 1'b1;
        repeat (5) begin
            tick();
            chk("rst_col", c4, 9'o000);
            chk("rst_sync", {7'b0, hs4, vs4}, 9'o000);
        end
        rst = 1'b0;

        // reset layout of the four squares
        px(0, 0);    chk("q0_origin", c4, RED);
        px(31, 31);  chk("q0_far", c4, RED);
        px(32, 0);   chk("q0_right_out", c4, BG);
        px(64, 32);  chk("q1_origin", c4, GRN);
        px(63, 32);  chk("q1_left_out", c4, BG);
        px(95, 63);  chk("q1_far", c4, GRN);
        px(96, 32);  chk("q1_right_out", c4, BG);
        px(128, 64); chk("q2_origin", c4, YEL);
        px(192, 96); chk("q3_origin", c4, BLU);

        // one frame step
        anim(480, 1);
        px(60, 36);  chk("q1_moved_left", c4, GRN);
        px(59, 36);  chk("q1_left_edge", c4, BG);
        px(5, 5);    chk("nq1_step_hit", c1, RED);
        px(3, 3);    chk("nq1_step_bg", c1, BG);
        px(35, 35);  chk("nq1_step_far", c1, RED);
        px(36, 35);  chk("nq1_step_out", c1, BG);

        // priority, blanking and sync delay on the two-square instance
        anim(96, 10);
        px(45, 65);  chk("prio_overlap", cp, RED);
        px(30, 65);  chk("prio_q1_only", cp, GRN);
        px(50, 80);  chk("prio_q1_low", cp, GRN);
        px(60, 45);  chk("prio_q0_only", cp, RED);
        sx = 10'd45; sy = 10'd65; de = 1'b0; tick();
        chk("blank_overlap", cp, 9'o000);
        sx = 10'd100; sy = 10'd100; de = 1'b1;
        hsync = 1'b1; vsync = 1'b0; tick();
        chk("hsync_delay_hi", {7'b0, hs4, vs4}, 9'o002);
        hsync = 1'b0; vsync = 1'b1; tick();
        chk("vsync_delay_hi", {7'b0, hs4, vs4}, 9'o001);
        hsync = 1'b0; vsync = 1'b0; tick();
        chk("sync_delay_lo", {7'b0, hs4, vs4}, 9'o000);

        // corner approach on a 70x70 screen
        anim(70, 10);
        px(38, 38);  chk("uc_far_clamp", cc, RED);
        px(37, 38);  chk("uc_far_out", cc, BG);
        anim(70, 9);
        px(2, 2);    chk("uc_at_2_2", cc, RED);
        px(1, 2);    chk("uc_left_of_2", cc, BG);
        px(2, 1);    chk("uc_above_2", cc, BG);
        anim(70, 1);
        px(0, 0);    chk("uc_corner", cc, RED);
        px(32, 32);  chk("uc_corner_out", cc, BG);
        anim(70, 1);
        px(4, 4);    chk("uc_both_flip", cc, RED);
        px(3, 3);    chk("uc_both_flip_out", cc, BG);

        // right-wall bounce of the single square
        anim(480, 151);
        px(608, 292); chk("wall_clamp", c1, RED);
        px(607, 292); chk("wall_clamp_out", c1, BG);
        anim(480, 1);
        px(608, 288); chk("wall_hold", c1, RED);
        px(639, 288); chk("wall_edge", c1, RED);
        px(607, 288); chk("wall_hold_out", c1, BG);
        anim(480, 1);
        px(604, 284); chk("wall_back", c1, RED);
        px(636, 284); chk("wall_back_out", c1, BG);

        // pause freezes motion across several frames
        pause = 1'b1;
        anim(480, 3);
        pause = 1'b0;
        px(604, 284); chk("pause_hold", c1, RED);
        px(603, 284); chk("pause_hold_out", c1, BG);

        // reset coincident with animate: reload only, no step
        rst = 1'b1; sx = '0; sy = 10'd480;
        de = 1'b1; hsync = 1'b1; vsync = 1'b0;
        tick();
        chk("rst_anim_col", c1, 9'o000);
        chk("rst_anim_sync", {7'b0, hs1, vs1}, 9'o000);
        rst = 1'b0;
        px(0, 0);    chk("rst_anim_origin", c1, RED);
        px(35, 35);  chk("rst_anim_nostep", c1, BG);
        px(64, 32);  chk("rst_anim_q1", c4, GRN);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
